// File: rtl/fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_sequencer : instruction-fetch controller driving MAR/IR over busC
// Revision 1.0
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclr,
  input  logic                  run,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rd,
  output logic [DATA_WIDTH-1:0] busC,
  output logic                  mar_en,
  output logic                  ir_en,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  fetch_done,
  output logic                  err
);

  // The counter only ever holds 0..TIMEOUT-1; reaching the last value with
  // mem_ready still low is the timeout event.
  localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDMAR = 3'd1,
    RD    = 3'd2,
    LDIR  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  mar_en_q, mar_en_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  ir_en_q, ir_en_d;
  logic                  fetch_done_q, fetch_done_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] busc_q, busc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (sclr) begin
      state_d = IDLE;
      pc_d    = '0;
      data_d  = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (jump_en) pc_d = jump_addr;
          if (run && !err_q) state_d = LDMAR;
        end
        LDMAR: state_d = RD;
        RD: begin
          if (mem_ready) begin
            data_d  = mem_rdata;
            cnt_d   = '0;
            state_d = LDIR;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LDIR: begin
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = DONE;
        end
        DONE: begin
          // A jump here replaces the increment made on the way out of LDIR.
          if (jump_en) pc_d = jump_addr;
          state_d = run ? LDMAR : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register while still coming straight from flops.
  always_comb begin
    mar_en_d     = (state_d == LDMAR);
    mem_rd_d     = (state_d == RD);
    ir_en_d      = (state_d == LDIR);
    fetch_done_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
    busc_d       = '0;
    if (state_d == LDMAR) begin
      busc_d[ADDR_WIDTH-1:0] = pc_d;
    end else if (state_d == LDIR) begin
      busc_d = data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      mar_en_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      ir_en_q      <= 1'b0;
      fetch_done_q <= 1'b0;
      busy_q       <= 1'b0;
      busc_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      mar_en_q     <= mar_en_d;
      mem_rd_q     <= mem_rd_d;
      ir_en_q      <= ir_en_d;
      fetch_done_q <= fetch_done_d;
      busy_q       <= busy_d;
      busc_q       <= busc_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign busC       = busc_q;
  assign mar_en     = mar_en_q;
  assign ir_en      = ir_en_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign fetch_done = fetch_done_q;
  assign err        = err_q;

endmodule
`default_nettype wire
